// File: rtl/lebug_pkg.sv
// lebug_pkg: shared pack-unit FSM states and default lane geometry
package lebug_pkg;
  localparam int N_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic {EMPTY, FILLING} state_t;
endpackage

// File: rtl/vector_scalar_pack_unit.sv
// vector_scalar_pack_unit: packs scalars into N-lane vectors, frame flush on eof; VSPU_ZERO_PAD_EN zeroes unused lanes
module vector_scalar_pack_unit
  import lebug_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  eof_in,
  input  logic [DATA_WIDTH-1:0] scalar_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
  output logic [$clog2(N):0]    count_out,
  output logic                  eof_out
);
  localparam int CW = $clog2(N) + 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_acc;
  logic emit;
  logic [DATA_WIDTH-1:0] lane [N-1:0];
  logic [DATA_WIDTH-1:0] lane_nxt [N-1:0];
  logic [DATA_WIDTH-1:0] out_lane [N-1:0];
  always_comb begin
    cnt_acc = cnt + CW'(valid_in);
    emit = (valid_in && cnt == CW'(N - 1)) || (eof_in && (state == FILLING || valid_in));
    cnt_nxt = emit ? '0 : cnt_acc;
    state_nxt = (cnt_nxt == '0) ? EMPTY : FILLING;
  end
  // out_lane sees the scalar accepted this cycle, so the flush takes it too
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lane_nxt[g] = (valid_in && cnt == CW'(g)) ? scalar_in : lane[g];
`ifdef VSPU_ZERO_PAD_EN
    assign out_lane[g] = (CW'(g) < cnt_acc) ? lane_nxt[g] : '0;
`else
    assign out_lane[g] = lane_nxt[g];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt <= '0;
      valid_out <= 1'b0;
      eof_out <= 1'b0;
      count_out <= '0;
      for (int i = 0; i < N; i++) begin
        lane[i] <= '0;
        vector_out[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      valid_out <= emit;
      for (int i = 0; i < N; i++) lane[i] <= lane_nxt[i];
      if (emit) begin
        eof_out <= eof_in;
        count_out <= cnt_acc;
        for (int i = 0; i < N; i++) vector_out[i] <= out_lane[i];
      end
    end
  end
endmodule

// File: tb/tb_vector_scalar_pack_unit.sv
// tb_vector_scalar_pack_unit: directed checks of the pack unit at N=8, DATA_WIDTH=32
module tb_vector_scalar_pack_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic eof_in = 1'b0;
  logic [31:0] scalar_in = '0;
  logic valid_out;
  logic [31:0] vector_out [7:0];
  logic [3:0] count_out;
  logic eof_out;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  vector_scalar_pack_unit #(.N(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in), .scalar_in(scalar_in),
    .valid_out(valid_out), .vector_out(vector_out), .count_out(count_out), .eof_out(eof_out)
  );
  task automatic step(input logic v, input logic e, input logic [31:0] d);
    valid_in = v;
    eof_in = e;
    scalar_in = d;
    @(negedge clk);
  endtask
  task automatic test_reset;
    #1;
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid_out); end
    n_chk++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_out); end
    n_chk++; if (eof_out !== 1'b0) begin n_fail++; $display("FAIL reset_eof got %0b want 0", eof_out); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (vector_out[i] !== 32'd0) begin n_fail++; $display("FAIL reset_lane%0d got %0d want 0", i, vector_out[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_full;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 32'(i));
      n_chk++; if (valid_out !== (i == 8)) begin n_fail++; $display("FAIL full_valid step %0d got %0b want %0b", i, valid_out, i == 8); end
    end
    n_chk++; if (count_out !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", count_out); end
    n_chk++; if (eof_out !== 1'b0) begin n_fail++; $display("FAIL full_eof got %0b want 0", eof_out); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (vector_out[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL full_lane%0d got %0d want %0d", i, vector_out[i], i + 1); end
    end
    step(1'b0, 1'b0, 32'd0);
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL full_pulse_width got %0b want 0", valid_out); end
    n_chk++; if (count_out !== 4'd8 || vector_out[7] !== 32'd8) begin n_fail++; $display("FAIL full_hold got count %0d lane7 %0d want 8 8", count_out, vector_out[7]); end
  endtask
  task automatic test_partial;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'(10 + i));
      n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL partial_early_valid step %0d got %0b want 0", i, valid_out); end
    end
    step(1'b0, 1'b1, 32'd0);
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL partial_valid got %0b want 1", valid_out); end
    n_chk++; if (count_out !== 4'd3) begin n_fail++; $display("FAIL partial_count got %0d want 3", count_out); end
    n_chk++; if (eof_out !== 1'b1) begin n_fail++; $display("FAIL partial_eof got %0b want 1", eof_out); end
    for (int i = 0; i < 8; i++) begin
`ifdef VSPU_ZERO_PAD_EN
      exp = (i < 3) ? 32'(10 + i) : 32'd0;
`else
      exp = (i < 3) ? 32'(10 + i) : 32'(i + 1);
`endif
      n_chk++; if (vector_out[i] !== exp) begin n_fail++; $display("FAIL partial_lane%0d got %0d want %0d", i, vector_out[i], exp); end
    end
    step(1'b0, 1'b0, 32'd0);
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL partial_pulse_width got %0b want 0", valid_out); end
  endtask
  task automatic test_coincident;
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 7, 32'(20 + i));
      if (valid_out) pulses++;
    end
    step(1'b0, 1'b0, 32'd0);
    if (valid_out) pulses++;
    n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL coinc_pulses got %0d want 1", pulses); end
    n_chk++; if (count_out !== 4'd8) begin n_fail++; $display("FAIL coinc_count got %0d want 8", count_out); end
    n_chk++; if (eof_out !== 1'b1) begin n_fail++; $display("FAIL coinc_eof got %0b want 1", eof_out); end
    n_chk++; if (vector_out[0] !== 32'd20 || vector_out[7] !== 32'd27) begin n_fail++; $display("FAIL coinc_lanes got %0d %0d want 20 27", vector_out[0], vector_out[7]); end
  endtask
  task automatic test_back_to_back;
    int first = -1;
    int second = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 32'(i));
      if (valid_out) begin
        if (first < 0) begin
          first = i;
          for (int k = 0; k < 8; k++) begin
            n_chk++; if (vector_out[k] !== 32'(k)) begin n_fail++; $display("FAIL b2b_first_lane%0d got %0d want %0d", k, vector_out[k], k); end
          end
        end else second = i;
      end
    end
    n_chk++; if (first !== 7 || second !== 15) begin n_fail++; $display("FAIL b2b_pulse_steps got %0d %0d want 7 15", first, second); end
    n_chk++; if (eof_out !== 1'b0 || count_out !== 4'd8) begin n_fail++; $display("FAIL b2b_tail got eof %0b count %0d want 0 8", eof_out, count_out); end
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (vector_out[k] !== 32'(8 + k)) begin n_fail++; $display("FAIL b2b_second_lane%0d got %0d want %0d", k, vector_out[k], 8 + k); end
    end
    step(1'b0, 1'b0, 32'd0);
  endtask
  task automatic test_reset_mid_frame;
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'(50 + i));
      if (valid_out) pulses++;
    end
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if (count_out !== 4'd0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_async got count %0d valid %0b want 0 0", count_out, valid_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'(100 + i));
      if (valid_out && i < 7) pulses++;
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_stray_pulses got %0d want 0", pulses); end
    n_chk++; if (valid_out !== 1'b1 || count_out !== 4'd8) begin n_fail++; $display("FAIL rst_vector got valid %0b count %0d want 1 8", valid_out, count_out); end
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (vector_out[k] !== 32'(100 + k)) begin n_fail++; $display("FAIL rst_lane%0d got %0d want %0d", k, vector_out[k], 100 + k); end
    end
    step(1'b0, 1'b0, 32'd0);
  endtask
  task automatic test_eof_empty;
    step(1'b0, 1'b1, 32'd0);
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL eof_empty_valid got %0b want 0", valid_out); end
    step(1'b0, 1'b0, 32'd0);
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL eof_empty_late got %0b want 0", valid_out); end
    n_chk++; if (count_out !== 4'd8 || eof_out !== 1'b0) begin n_fail++; $display("FAIL eof_empty_hold got count %0d eof %0b want 8 0", count_out, eof_out); end
    step(1'b1, 1'b0, 32'd77);
    step(1'b0, 1'b1, 32'd0);
    n_chk++; if (valid_out !== 1'b1 || count_out !== 4'd1 || vector_out[0] !== 32'd77) begin n_fail++; $display("FAIL eof_after_empty got valid %0b count %0d lane0 %0d want 1 1 77", valid_out, count_out, vector_out[0]); end
  endtask
  initial begin
    test_reset();
    test_full();
    test_partial();
    test_coincident();
    test_back_to_back();
    test_reset_mid_frame();
    test_eof_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_scalar_pack_unit.md
VECTOR_SCALAR_PACK_UNIT -- requirements
Module: vector_scalar_pack_unit

Interface
REQ-001 SHALL have parameter N, default 8, the number of lanes in the output vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the width of each scalar and each lane.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port valid_in, input, 1, scalar_in carries a reduced value this cycle.
REQ-006 SHALL have port eof_in, input, 1, end of frame; flushes any partial vector.
REQ-007 SHALL have port scalar_in, input, DATA_WIDTH, one reduced value.
REQ-008 SHALL have port valid_out, output, 1, a one-cycle pulse marking vector_out/count_out as valid.
REQ-009 SHALL have port vector_out, output, N x DATA_WIDTH unpacked array [N-1:0], the packed lanes, lane 0 filled first.
REQ-010 SHALL have port count_out, output, $clog2(N)+1, the number of valid lanes (1..N) when valid_out=1.
REQ-011 SHALL have port eof_out, output, 1, asserted with valid_out when the emitted vector closes a frame.

Function
REQ-012 SHALL use a two-state FSM: EMPTY (fill count 0) and FILLING (fill count 1..N-1).
REQ-013 SHALL write scalar_in into lane[fill count] and increment the count on each valid_in cycle; no backpressure; every valid_in is accepted.
REQ-014 SHALL emit a vector when the Nth scalar is accepted: valid_out=1 the next cycle, count_out=N, fill count returns to 0, state EMPTY.
REQ-015 SHALL flush on eof_in with valid_in=0 in FILLING: valid_out=1 the next cycle, count_out=current count, eof_out=1, state EMPTY.
REQ-016 SHALL handle eof_in with valid_in=1 by accepting the scalar first, then flushing (count+1 lanes, eof_out=1).
REQ-017 SHALL emit a single vector when the Nth scalar and eof_in coincide: count_out=N, eof_out=1.
REQ-018 SHALL treat eof_in in EMPTY with valid_in=0 as a no-op (no output).
REQ-019 SHALL drive valid_out for exactly one cycle per emitted vector; latency from the final accepted scalar to valid_out is exactly 1 cycle.
REQ-020 SHALL keep a scalar accepted in the cycle valid_out is high as the start of the next vector (lane 0), with no bubble.
REQ-021 SHALL keep vector_out, count_out and eof_out stable between valid_out pulses.

Reset
REQ-022 SHALL on rst_n=0, immediately and asynchronously set valid_out=0, eof_out=0, count_out=0, all vector_out lanes=0, fill count=0, state EMPTY.
REQ-023 SHALL discard a partial vector on reset mid-frame with no output; the first scalar after release goes to lane 0.

Configuration
REQ-024 SHALL support macro VSPU_ZERO_PAD_EN: when defined, lanes at index >= count_out in an emitted vector SHALL be zero.
REQ-025 SHALL, when VSPU_ZERO_PAD_EN is undefined, leave unused lanes holding their previous contents; count_out alone qualifies them.

Structure
REQ-026 SHALL take the FSM state enum (EMPTY, FILLING) from a shared package, lebug_pkg, together with the default N and DATA_WIDTH constants.
REQ-027 SHALL be a single module with no sub-module; the lane write and count logic are too small to justify one.

Verification (N=8, DATA_WIDTH=32)
REQ-028 SHALL cover a full vector: 8 consecutive valid scalars 1..8 -> one cycle later valid_out=1, lanes 0..7=1..8, count_out=8, eof_out=0.
REQ-029 SHALL cover a partial flush: scalars 10,11,12, then eof_in alone -> valid_out=1, count_out=3, lanes 0..2=10,11,12, eof_out=1; with VSPU_ZERO_PAD_EN, lanes 3..7=0.
REQ-030 SHALL cover a coincident end: 7 scalars, then 8th scalar with eof_in -> exactly one output, count_out=8, eof_out=1.
REQ-031 SHALL cover back-to-back streaming: 16 consecutive scalars 0..15 -> two pulses, 8 cycles apart; the second has lanes 0..7=8..15.
REQ-032 SHALL cover reset mid-frame: 5 scalars, rst_n low for 1 cycle, then 8 scalars 100..107 -> no output for the first 5; one vector 100..107, count_out=8.
REQ-033 SHALL cover eof on empty: eof_in with no data pending -> valid_out stays 0.
